m68k_bus_responder: RTL

M68K_BUS_RESPONDER -- requirements
Module: m68k_bus_responder

---
 rtl/m68k_bus_responder_if.sv | 33 +++
 rtl/m68k_bus_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_responder_if.sv
// m68k_bus_responder_if
// Bus bundle between a 68000-style CPU (master) and the bus responder (slave).
//   AS_N, UDS_N, LDS_N : address / upper / lower data strobes, active low
//   RW_IN              : read(1) / write(0)
//   ADDR_IN[23:1]      : CPU word address A23..A1
//   DTACK_N, BERR_N    : transfer acknowledge / bus error, active low
//   ROM_CS_N, RAM_CS_N, IO_CS_N : region chip selects, active low
//   OE_N, WE_U_N, WE_L_N        : read enable and byte-lane write enables, active low
interface m68k_bus_responder_if;
  logic        AS_N;
  logic        UDS_N;
  logic        LDS_N;
  logic        RW_IN;
  logic [23:1] ADDR_IN;
  logic        DTACK_N;
  logic        BERR_N;
  logic        ROM_CS_N;
  logic        RAM_CS_N;
  logic        IO_CS_N;
  logic        OE_N;
  logic        WE_U_N;
  logic        WE_L_N;

  modport slave (
    input  AS_N, UDS_N, LDS_N, RW_IN, ADDR_IN,
    output DTACK_N, BERR_N, ROM_CS_N, RAM_CS_N, IO_CS_N, OE_N, WE_U_N, WE_L_N
  );

  modport master (
    output AS_N, UDS_N, LDS_N, RW_IN, ADDR_IN,
    input  DTACK_N, BERR_N, ROM_CS_N, RAM_CS_N, IO_CS_N, OE_N, WE_U_N, WE_L_N
  );
endinterface

// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder
// Decodes 68000 bus cycles into ROM / RAM / IO chip selects, inserts per-region
// wait states and returns DTACK_N. Unmapped accesses raise BERR_N after a
// timeout when BUS_TIMEOUT_EN is defined; otherwise they are held without
// acknowledge until the CPU drops AS_N, and BERR_N stays high.
// Ports:
//   MCLK_IN  : master clock, all state on its rising edge
//   RESET_IN : asynchronous active-high reset
//   bus      : m68k_bus_responder_if.slave (strobes, RW, address in;
//              DTACK_N, BERR_N, chip selects, OE_N, WE_U_N, WE_L_N out)
// Parameters: ROM_WAIT, RAM_WAIT, IO_WAIT (0-15), TIMEOUT (16-255).
// Configuration macro: BUS_TIMEOUT_EN
module m68k_bus_responder #(
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned RAM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 3,
  parameter int unsigned TIMEOUT  = 255
) (
  input logic MCLK_IN,
  input logic RESET_IN,
  m68k_bus_responder_if.slave bus
);

  if (ROM_WAIT > 15 || RAM_WAIT > 15 || IO_WAIT > 15 ||
      TIMEOUT < 16 || TIMEOUT > 255) begin : g_param_check
    $error("m68k_bus_responder: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
`ifdef BUS_TIMEOUT_EN
    S_TMO_WAIT,
`endif
    S_ACK
  } state_t;

  typedef enum logic [1:0] {
    R_ROM,
    R_RAM,
    R_IO,
    R_NONE
  } region_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       as_meta, as_s;

  region_t    reg_q, reg_d;
  logic       rw_q, rw_d;
  logic       uds_q, uds_d;
  logic       lds_q, lds_d;

  logic       dtack_q, dtack_d;
  logic       berr_q, berr_d;
  logic       rom_cs_q, rom_cs_d;
  logic       ram_cs_q, ram_cs_d;
  logic       io_cs_q, io_cs_d;
  logic       oe_q, oe_d;
  logic       we_u_q, we_u_d;
  logic       we_l_q, we_l_d;

  logic       mapped;
  logic       active;

  function automatic region_t decode_region(input logic [3:0] nib);
    case (nib)
      4'h0:    decode_region = R_ROM;
      4'h1:    decode_region = R_RAM;
      4'hF:    decode_region = R_IO;
      default: decode_region = R_NONE;
    endcase
  endfunction

  function automatic logic [7:0] wait_of(input region_t r);
    case (r)
      R_ROM:   wait_of = 8'(ROM_WAIT);
      R_RAM:   wait_of = 8'(RAM_WAIT);
      default: wait_of = 8'(IO_WAIT);
    endcase
  endfunction

  always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      as_meta  <= 1'b1;
      as_s     <= 1'b1;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      reg_q    <= R_NONE;
      rw_q     <= 1'b1;
      uds_q    <= 1'b1;
      lds_q    <= 1'b1;
      dtack_q  <= 1'b1;
      berr_q   <= 1'b1;
      rom_cs_q <= 1'b1;
      ram_cs_q <= 1'b1;
      io_cs_q  <= 1'b1;
      oe_q     <= 1'b1;
      we_u_q   <= 1'b1;
      we_l_q   <= 1'b1;
    end else begin
      as_meta  <= bus.AS_N;
      as_s     <= as_meta;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reg_q    <= reg_d;
      rw_q     <= rw_d;
      uds_q    <= uds_d;
      lds_q    <= lds_d;
      dtack_q  <= dtack_d;
      berr_q   <= berr_d;
      rom_cs_q <= rom_cs_d;
      ram_cs_q <= ram_cs_d;
      io_cs_q  <= io_cs_d;
      oe_q     <= oe_d;
      we_u_q   <= we_u_d;
      we_l_q   <= we_l_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    reg_d   = reg_q;
    rw_d    = rw_q;
    uds_d   = uds_q;
    lds_d   = lds_q;

    case (state_q)
      S_IDLE: begin
        if (!as_s) begin
          state_d = S_DECODE;
          reg_d   = decode_region(bus.ADDR_IN[23:20]);
          rw_d    = bus.RW_IN;
          uds_d   = bus.UDS_N;
          lds_d   = bus.LDS_N;
        end
      end
      S_DECODE: begin
        if (as_s) begin
          state_d = S_IDLE;
        end else if (reg_q != R_NONE) begin
          state_d = S_WAIT;
          cnt_d   = wait_of(reg_q);
        end else begin
`ifdef BUS_TIMEOUT_EN
          state_d = S_TMO_WAIT;
          cnt_d   = 8'(TIMEOUT - 1);
`else
          state_d = S_DECODE;
`endif
        end
      end
      S_WAIT: begin
        if (as_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
`ifdef BUS_TIMEOUT_EN
      S_TMO_WAIT: begin
        if (as_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
`endif
      S_ACK: begin
        if (as_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so every pin comes off a flop
  // and changes on the same edge as the state it reflects. The latched region
  // is stable by then: it only changes on IDLE->DECODE, where outputs are idle.
  always_comb begin
    mapped   = (reg_q != R_NONE);
    active   = (state_d == S_WAIT) || ((state_d == S_ACK) && mapped);
    rom_cs_d = !(active && (reg_q == R_ROM));
    ram_cs_d = !(active && (reg_q == R_RAM));
    io_cs_d  = !(active && (reg_q == R_IO));
    oe_d     = !(active && rw_q);
    we_u_d   = !(active && !rw_q && !uds_q);
    we_l_d   = !(active && !rw_q && !lds_q);
    dtack_d  = !((state_d == S_ACK) && mapped);
`ifdef BUS_TIMEOUT_EN
    berr_d   = !((state_d == S_ACK) && !mapped);
`else
    berr_d   = 1'b1;
`endif
  end

  assign bus.DTACK_N  = dtack_q;
`ifdef BUS_TIMEOUT_EN
  assign bus.BERR_N   = berr_q;
`else
  assign bus.BERR_N   = 1'b1;
`endif
  assign bus.ROM_CS_N = rom_cs_q;
  assign bus.RAM_CS_N = ram_cs_q;
  assign bus.IO_CS_N  = io_cs_q;
  assign bus.OE_N     = oe_q;
  assign bus.WE_U_N   = we_u_q;
  assign bus.WE_L_N   = we_l_q;

endmodule
